// File: rtl/fifo_wr_arbiter.sv
//==============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one async-FIFO write port.
//            Optional per-requester beat counters via FIFO_ARB_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_words
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [GW-1:0] last_grant, last_nx, grant_nx;
  logic [CW-1:0] burst_cnt, cnt_nx;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          holder_valid;
  logic          can_accept;
  logic          beat;
  logic          burst_end;

  // Search begins one past the last winner, so the holder only wins
  // re-arbitration when nobody else is asking.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_grant) + k) % NUM_REQ;
      if (!pick_found && req_valid[GW'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(j);
      end
    end
  end

  assign holder_valid = req_valid[grant_id];
  assign can_accept   = (state == BURST) && !fifo_full;
  assign beat         = can_accept && holder_valid;
  assign burst_end    = !holder_valid || (beat && (burst_cnt == C_LAST_BEAT));

  assign req_ready  = can_accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign fifo_wr_en = beat;
  assign fifo_data  = (state == BURST) ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy       = (state == BURST);

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    last_nx  = last_grant;
    cnt_nx   = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx = BURST;
          grant_nx = pick_idx;
          last_nx  = pick_idx;
          cnt_nx   = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          cnt_nx = '0;
          if (pick_found) begin
            grant_nx = pick_idx;
            last_nx  = pick_idx;
          end else begin
            state_nx = IDLE;
          end
        end else if (beat) begin
          cnt_nx = burst_cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nx;
      grant_id   <= grant_nx;
      last_grant <= last_nx;
      burst_cnt  <= cnt_nx;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [15:0] words;
    always_ff @(posedge clk) begin
      if (rst) begin
        words <= '0;
      end else if (req_valid[i] && req_ready[i] && (words != 16'hFFFF)) begin
        words <= words + 16'd1;
      end
    end
    assign stat_words[i*16 +: 16] = words;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//==============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed self-checking bench for fifo_wr_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_words;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_words (stat_words)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] val);
    req_data[idx*DW +: DW] = val;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);

    // Single requester 2, 20 words, bursts of 8/8/4 re-granted back to back
    cyc(); rst = 1'b0; req_valid = 4'b0100; set_data(2, 8'h00); #1;
    check("single_first_idle", fifo_wr_en, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(); set_data(2, DW'(i)); #1;
      check("single_wr_en", fifo_wr_en, 1);
      check("single_data", fifo_data, i);
      check("single_grant", grant_id, 2);
    end
    cyc(); req_valid = '0; #1;
    check("single_drop_wr_en", fifo_wr_en, 0);
    check("single_drop_busy", busy, 1);
    cyc(); #1;
    check("single_idle", busy, 0);

    // Round-robin fairness from a fresh reset: 0,1,2,3,0,... every 8 beats
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, DW'(8'hA0 + i));
    req_valid = 4'b1111; #1;
    check("rr_idle_cycle", fifo_wr_en, 0);
    for (int k = 0; k < 64; k++) begin
      cyc(); #1;
      check("rr_grant", grant_id, (k / 8) % 4);
      check("rr_wr_en", fifo_wr_en, 1);
      check("rr_data", fifo_data, 8'hA0 + (k / 8) % 4);
      check("rr_ready", req_ready, 1 << ((k / 8) % 4));
    end
    cyc(); req_valid = '0; #1;
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) check("stat_words", stat_words[i*16 +: 16], 16);
`endif
    check("rr_drop_wr_en", fifo_wr_en, 0);
    cyc(); #1;
    check("rr_idle", busy, 0);

    // Backpressure on requester 1 (requester 3 also waiting), stall after beat 3
    cyc(); req_valid = 4'b1010; set_data(1, 8'h10); set_data(3, 8'h33); #1;
    check("bp_idle_cycle", fifo_wr_en, 0);
    for (int b = 0; b < 3; b++) begin
      cyc(); set_data(1, DW'(8'h10 + b)); #1;
      check("bp_pre_wr_en", fifo_wr_en, 1);
      check("bp_pre_data", fifo_data, 8'h10 + b);
      check("bp_pre_grant", grant_id, 1);
    end
    for (int s = 0; s < 5; s++) begin
      cyc(); fifo_full = 1'b1; set_data(1, 8'h13); #1;
      check("bp_stall_ready", req_ready, 0);
      check("bp_stall_wr_en", fifo_wr_en, 0);
      check("bp_stall_busy", busy, 1);
      check("bp_stall_grant", grant_id, 1);
    end
    for (int b = 3; b < 8; b++) begin
      cyc(); fifo_full = 1'b0; set_data(1, DW'(8'h10 + b)); #1;
      check("bp_post_wr_en", fifo_wr_en, 1);
      check("bp_post_data", fifo_data, 8'h10 + b);
      check("bp_post_grant", grant_id, 1);
    end
    cyc(); #1;
    check("bp_next_grant", grant_id, 3);
    check("bp_next_data", fifo_data, 8'h33);
    cyc(); req_valid = '0; #1;
    check("bp_drop_wr_en", fifo_wr_en, 0);
    cyc(); #1;
    check("bp_idle", busy, 0);

    // Early release: requester 3 drops after 2 beats, requester 0 waiting
    cyc(); req_valid = 4'b1000; set_data(0, 8'h5A); set_data(3, 8'h31); #1;
    check("er_idle_cycle", fifo_wr_en, 0);
    cyc(); #1;
    check("er_beat1_grant", grant_id, 3);
    check("er_beat1_wr_en", fifo_wr_en, 1);
    cyc(); req_valid = 4'b1001; #1;
    check("er_beat2_data", fifo_data, 8'h31);
    check("er_beat2_ready", req_ready, 4'b1000);
    cyc(); req_valid = 4'b0001; #1;
    check("er_release_wr_en", fifo_wr_en, 0);
    check("er_release_busy", busy, 1);
    cyc(); #1;
    check("er_new_grant", grant_id, 0);
    check("er_new_wr_en", fifo_wr_en, 1);
    check("er_new_data", fifo_data, 8'h5A);
    check("er_no_bubble", busy, 1);
    cyc(); req_valid = '0; #1;
    cyc(); #1;
    check("er_idle", busy, 0);

    // Reset during the 4th beat of a burst from requester 2
    cyc(); req_valid = 4'b0100; set_data(2, 8'h77); #1;
    for (int b = 0; b < 3; b++) begin
      cyc(); #1;
      check("rm_beat_wr_en", fifo_wr_en, 1);
    end
    cyc(); rst = 1'b1; #1;
    check("rm_4th_wr_en", fifo_wr_en, 1);
    check("rm_4th_grant", grant_id, 2);
    cyc(); rst = 1'b0; req_valid = 4'b0101; #1;
    check("rm_after_wr_en", fifo_wr_en, 0);
    check("rm_after_busy", busy, 0);
    check("rm_after_ready", req_ready, 0);
    cyc(); #1;
    check("rm_regrant_id", grant_id, 0);
    check("rm_regrant_wr_en", fifo_wr_en, 1);
    check("rm_regrant_data", fifo_data, 8'h5A);
    cyc(); req_valid = '0; #1;
    cyc(); #1;
    check("rm_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
